xilinx_distram_delay_line: RTL and testbench

//  Controller that turns xilinx_sp_distram into a run-time-programmable streaming delay line.

---
 rtl/xilinx_distram_pkg.sv | 31 +++
 rtl/xilinx_sp_distram.sv | 34 +++
 rtl/xilinx_distram_delay_line.sv | 74 +++++++
 tb/tb_xilinx_distram_delay_line.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/xilinx_distram_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : xilinx_distram_pkg                                               |
// | Brief   : Width and depth helpers shared by the distributed-RAM blocks.    |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package xilinx_distram_pkg;

   localparam int unsigned c_DEF_ADDR_WIDTH = 6;
   localparam int unsigned c_DEF_DATA_WIDTH = 1;

   // Number of RAM words addressable with aw address bits.
   function automatic int unsigned depth_of(input int unsigned aw);
      return 32'd1 << aw;
   endfunction

   // Fill counter needs one extra bit so it can hold a full ring of 2**aw entries.
   function automatic int unsigned fill_width(input int unsigned aw);
      return aw + 32'd1;
   endfunction

   function automatic int unsigned addr_width(input int unsigned aw);
      return aw;
   endfunction

   function automatic int unsigned ring_len(input int unsigned len);
      return len + 32'd1;
   endfunction

endpackage : xilinx_distram_pkg
`default_nettype wire

// File: rtl/xilinx_sp_distram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : xilinx_sp_distram                                                |
// | Brief   : Single-port distributed RAM, sync write, async read.             |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module xilinx_sp_distram
   import xilinx_distram_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = c_DEF_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH = c_DEF_DATA_WIDTH
) (
   input  logic                  WCLK,
   input  logic [ADDR_WIDTH-1:0] A,
   input  logic [DATA_WIDTH-1:0] D,
   input  logic                  WE,
   output logic [DATA_WIDTH-1:0] O
);

   localparam int unsigned c_DEPTH = depth_of(ADDR_WIDTH);

   // No reset: LUT RAM contents cannot be cleared in one cycle.
   logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];

   always_ff @(posedge WCLK) begin
      if (WE) begin
         r_mem[A] <= D;
      end
   end

   assign O = r_mem[A];

endmodule : xilinx_sp_distram
`default_nettype wire

// File: rtl/xilinx_distram_delay_line.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : xilinx_distram_delay_line                                        |
// | Brief   : Programmable streaming delay line controller for a distributed   |
// |           RAM: read-before-write on one circular address per sample.       |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module xilinx_distram_delay_line
   import xilinx_distram_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = c_DEF_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH = c_DEF_DATA_WIDTH
) (
   input  logic                  WCLK,
   input  logic                  RST,
   input  logic [ADDR_WIDTH-1:0] LEN,
   input  logic                  FLUSH,
   input  logic                  S_VALID,
   input  logic [DATA_WIDTH-1:0] S_DATA,
   output logic                  M_VALID,
   output logic [DATA_WIDTH-1:0] M_DATA,
   output logic                  PRIMED,
   output logic [ADDR_WIDTH-1:0] RAM_A,
   output logic [DATA_WIDTH-1:0] RAM_D,
   output logic                  RAM_WE,
   input  logic [DATA_WIDTH-1:0] RAM_O
);

   localparam int unsigned c_FILL_W = fill_width(ADDR_WIDTH);
   localparam int unsigned c_ADDR_W = addr_width(ADDR_WIDTH);

   logic [c_ADDR_W-1:0]   r_len;
   logic [c_ADDR_W-1:0]   r_ptr;
   logic [c_FILL_W-1:0]   r_fill;
   logic                  r_mvalid;
   logic [DATA_WIDTH-1:0] r_mdata;

   logic [c_FILL_W-1:0]   w_ring_len;
   logic                  w_full;
   logic                  w_clear;

   assign w_clear    = RST | FLUSH;
   assign w_ring_len = {1'b0, r_len} + c_FILL_W'(1);
   assign w_full     = (r_fill == w_ring_len);

   always_ff @(posedge WCLK) begin
      if (w_clear) begin
         r_len    <= LEN;
         r_ptr    <= '0;
         r_fill   <= '0;
         r_mvalid <= 1'b0;
         r_mdata  <= '0;
      end else if (S_VALID) begin
         // RAM_O still shows the word being overwritten on this edge.
         r_mdata  <= RAM_O;
         r_mvalid <= w_full;
         r_ptr    <= (r_ptr == r_len) ? '0 : r_ptr + c_ADDR_W'(1);
         if (!w_full) begin
            r_fill <= r_fill + c_FILL_W'(1);
         end
      end else begin
         r_mvalid <= 1'b0;
      end
   end

   assign M_VALID = r_mvalid;
   assign M_DATA  = r_mdata;
   assign PRIMED  = w_full;
   assign RAM_A   = r_ptr;
   assign RAM_D   = S_DATA;
   assign RAM_WE  = S_VALID & ~w_clear;

endmodule : xilinx_distram_delay_line
`default_nettype wire

// File: tb/tb_xilinx_distram_delay_line.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_xilinx_distram_delay_line                                     |
// | Brief   : Directed self-checking bench for the delay line plus its RAM.    |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_xilinx_distram_delay_line;

   localparam int unsigned AW = 6;
   localparam int unsigned DW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] len;
   logic          flush;
   logic          s_valid;
   logic [DW-1:0] s_data;
   logic          m_valid;
   logic [DW-1:0] m_data;
   logic          primed;
   logic [AW-1:0] ram_a;
   logic [DW-1:0] ram_d;
   logic          ram_we;
   logic [DW-1:0] ram_o;

   int n_checks = 0;
   int n_bad    = 0;

   always #5 clk = ~clk;

   xilinx_distram_delay_line #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .WCLK(clk), .RST(rst), .LEN(len), .FLUSH(flush),
      .S_VALID(s_valid), .S_DATA(s_data),
      .M_VALID(m_valid), .M_DATA(m_data), .PRIMED(primed),
      .RAM_A(ram_a), .RAM_D(ram_d), .RAM_WE(ram_we), .RAM_O(ram_o)
   );

   xilinx_sp_distram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ram (
      .WCLK(clk), .A(ram_a), .D(ram_d), .WE(ram_we), .O(ram_o)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic [AW-1:0] l);
      rst = 1'b1; len = l; s_valid = 1'b0; flush = 1'b0;
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; len = 6'd3; s_valid = 1'b1; s_data = 8'h77; flush = 1'b0;
      #1;
      n_checks++;
      if (ram_we !== 1'b0) begin
         n_bad++; $display("FAIL reset_we: got %b want 0", ram_we);
      end
      step();
      s_valid = 1'b0; rst = 1'b0;
      n_checks++;
      if (m_valid !== 1'b0 || m_data !== 8'h00 || primed !== 1'b0 || ram_a !== 6'd0) begin
         n_bad++;
         $display("FAIL reset_state: got v=%b d=%h p=%b a=%0d want v=0 d=00 p=0 a=0",
                  m_valid, m_data, primed, ram_a);
      end
   endtask

   // LEN=3, continuous stream 0x01..0x0C: output i = input i-4.
   task automatic test_stream();
      do_reset(6'd3);
      for (int i = 0; i < 12; i++) begin
         s_valid = 1'b1; s_data = 8'(i + 1);
         step();
         n_checks++;
         if (m_valid !== (i >= 4) || (i >= 4 && m_data !== 8'(i - 3)) || primed !== (i >= 3)) begin
            n_bad++;
            $display("FAIL stream[%0d]: got v=%b d=%h p=%b want v=%b d=%h p=%b",
                     i, m_valid, m_data, primed, (i >= 4), 8'(i - 3), (i >= 3));
         end
      end
      s_valid = 1'b0;
   endtask

   task automatic test_len0();
      do_reset(6'd0);
      s_valid = 1'b1; s_data = 8'hA5;
      step();
      n_checks++;
      if (m_valid !== 1'b0 || primed !== 1'b1) begin
         n_bad++; $display("FAIL len0_first: got v=%b p=%b want v=0 p=1", m_valid, primed);
      end
      s_data = 8'h5A;
      step();
      s_valid = 1'b0;
      n_checks++;
      if (m_valid !== 1'b1 || m_data !== 8'hA5) begin
         n_bad++; $display("FAIL len0_out: got v=%b d=%h want v=1 d=a5", m_valid, m_data);
      end
      step();
      n_checks++;
      if (m_valid !== 1'b0 || m_data !== 8'hA5) begin
         n_bad++; $display("FAIL len0_pulse: got v=%b d=%h want v=0 d=a5", m_valid, m_data);
      end
   endtask

   // Full depth: ring of 64, 200 samples, pointer wraps 63->0 repeatedly.
   task automatic test_full_depth();
      do_reset(6'd63);
      for (int i = 0; i < 200; i++) begin
         s_valid = 1'b1; s_data = 8'(i * 7 + 3);
         #1;
         n_checks++;
         if (ram_a !== 6'(i % 64)) begin
            n_bad++; $display("FAIL full_ptr[%0d]: got %0d want %0d", i, ram_a, i % 64);
         end
         step();
         n_checks++;
         if (m_valid !== (i >= 64) || (i >= 64 && m_data !== 8'((i - 64) * 7 + 3))) begin
            n_bad++;
            $display("FAIL full_out[%0d]: got v=%b d=%h want v=%b d=%h",
                     i, m_valid, m_data, (i >= 64), 8'((i - 64) * 7 + 3));
         end
      end
      s_valid = 1'b0;
   endtask

   // Alternate-cycle input: delay stays 4 samples, never valid on idle cycles.
   task automatic test_gaps();
      do_reset(6'd3);
      for (int i = 0; i < 16; i++) begin
         s_valid = 1'b1; s_data = 8'(8'h10 + i);
         step();
         n_checks++;
         if (m_valid !== (i >= 4) || (i >= 4 && m_data !== 8'(8'h10 + i - 4))) begin
            n_bad++;
            $display("FAIL gaps_out[%0d]: got v=%b d=%h want v=%b d=%h",
                     i, m_valid, m_data, (i >= 4), 8'(8'h10 + i - 4));
         end
         s_valid = 1'b0;
         step();
         n_checks++;
         if (m_valid !== 1'b0) begin
            n_bad++; $display("FAIL gaps_idle[%0d]: got v=%b want v=0", i, m_valid);
         end
      end
   endtask

   task automatic test_flush();
      do_reset(6'd3);
      for (int i = 0; i < 6; i++) begin
         s_valid = 1'b1; s_data = 8'(8'h20 + i);
         step();
      end
      flush = 1'b1; len = 6'd1; s_valid = 1'b1; s_data = 8'hEE;
      #1;
      n_checks++;
      if (ram_we !== 1'b0) begin
         n_bad++; $display("FAIL flush_we: got %b want 0", ram_we);
      end
      step();
      flush = 1'b0; s_valid = 1'b0;
      n_checks++;
      if (m_valid !== 1'b0 || primed !== 1'b0 || m_data !== 8'h00 || ram_a !== 6'd0) begin
         n_bad++;
         $display("FAIL flush_state: got v=%b p=%b d=%h a=%0d want v=0 p=0 d=00 a=0",
                  m_valid, primed, m_data, ram_a);
      end
      for (int i = 0; i < 6; i++) begin
         s_valid = 1'b1; s_data = 8'(8'h30 + i);
         step();
         n_checks++;
         if (m_valid !== (i >= 2) || (i >= 2 && m_data !== 8'(8'h30 + i - 2))) begin
            n_bad++;
            $display("FAIL flush_refill[%0d]: got v=%b d=%h want v=%b d=%h",
                     i, m_valid, m_data, (i >= 2), 8'(8'h30 + i - 2));
         end
      end
      s_valid = 1'b0;
   endtask

   // Reset while primed, then LEN moved outside reset and must be ignored.
   task automatic test_rst_primed();
      n_checks++;
      if (primed !== 1'b1) begin
         n_bad++; $display("FAIL rstp_pre: got p=%b want p=1", primed);
      end
      rst = 1'b1; len = 6'd2; s_valid = 1'b1; s_data = 8'h99;
      step();
      rst = 1'b0; s_valid = 1'b0; len = 6'd0;
      n_checks++;
      if (m_valid !== 1'b0 || m_data !== 8'h00 || primed !== 1'b0) begin
         n_bad++;
         $display("FAIL rstp_state: got v=%b d=%h p=%b want v=0 d=00 p=0", m_valid, m_data, primed);
      end
      for (int i = 0; i < 7; i++) begin
         s_valid = 1'b1; s_data = 8'(8'h40 + i);
         step();
         n_checks++;
         if (primed !== (i >= 2) || m_valid !== (i >= 3) ||
             (i >= 3 && m_data !== 8'(8'h40 + i - 3))) begin
            n_bad++;
            $display("FAIL rstp_refill[%0d]: got v=%b d=%h p=%b want v=%b d=%h p=%b",
                     i, m_valid, m_data, primed, (i >= 3), 8'(8'h40 + i - 3), (i >= 2));
         end
      end
      s_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; len = '0; flush = 1'b0; s_valid = 1'b0; s_data = '0;
      step();
      test_reset();
      test_stream();
      test_len0();
      test_full_depth();
      test_gaps();
      test_flush();
      test_rst_primed();
      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule : tb_xilinx_distram_delay_line
`default_nettype wire
